vga_timing_driver: RTL and testbench

- Generates 640x480@60 VGA timing from the board clock.
- Drives pixel counters hc_out/vc_out into the graphics pipeline and takes back its 8-bit RGB332 colour.
- Produces pin-level hsync/vsync and 4-bit-per-channel RGB, with sync delayed to match the colour pipeline.
- Sits between the top level and the graphics/maze/ghost blocks; it is the consumer of the colour those blocks produce.

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_sync_pipe.sv | 40 ++++
 rtl/vga_timing_driver.sv | 132 +++++++++++++
 tb/tb_vga_timing_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, RGB332 pixel type, palette and
// the pin-level colour expansion used by the timing driver.
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } sync_t;

    // Blanked, both syncs idle-high
    localparam sync_t SYNC_IDLE = 3'b011;

    localparam rgb332_t RED = 8'hE0;
    localparam rgb332_t PNK = 8'hF3;
    localparam rgb332_t CYN = 8'h1F;
    localparam rgb332_t ORG = 8'hF4;
    localparam rgb332_t YLW = 8'hFC;
    localparam rgb332_t WHT = 8'hFF;
    localparam rgb332_t CRM = 8'hFE;
    localparam rgb332_t BLU = 8'h03;
    localparam rgb332_t BLK = 8'h00;

    // Replicate MSBs so full-scale RGB332 maps to full-scale 4-bit pins
    function automatic logic [11:0] expand_rgb332(input rgb332_t c);
        return {c.r, c.r[2], c.g, c.g[2], c.b, c.b};
    endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// Delays {active, hs, vs} by DEPTH pixel ticks so the sync pins line up with
// colour coming back from the graphics pipeline.
module vga_sync_pipe
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_tick,
    input  sync_t i_sync,
    output sync_t o_sync
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, i_tick};
            assign o_sync   = i_sync;
        end else begin : g_shift
            sync_t r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= SYNC_IDLE;
                    end
                end else if (i_tick) begin
                    r_stage[0] <= i_sync;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_sync = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_driver.sv
// VGA timing generator: pixel-rate divider, h/v counters, pipeline-aligned
// sync and RGB332-to-pin colour output stage.
module vga_timing_driver
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int PIPE_DELAY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] color_in,
    output logic [9:0] hc_out,
    output logic [9:0] vc_out,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hc;
    logic [9:0]       r_vc;
    logic             r_hsync;
    logic             r_vsync;
    logic [3:0]       r_red;
    logic [3:0]       r_green;
    logic [3:0]       r_blue;

    logic             w_tick;
    logic             w_hWrap;
    logic             w_vWrap;
    sync_t            w_raw;
    sync_t            w_dly;

    // Tick is gated by reset so no counter or pipeline advance leaks through it
    assign w_tick  = (r_div == DIV_LAST) && !rst;
    assign w_hWrap = (r_hc == H_LAST);
    assign w_vWrap = (r_vc == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_tick) begin
            if (w_hWrap) begin
                r_hc <= '0;
                r_vc <= w_vWrap ? 10'd0 : r_vc + 10'd1;
            end else begin
                r_hc <= r_hc + 10'd1;
            end
        end
    end

    assign w_raw = '{
        active: (r_hc < 10'(H_VISIBLE)) && (r_vc < 10'(V_VISIBLE)),
        hs:     !((r_hc >= 10'(HS_START)) && (r_hc <= 10'(HS_END))),
        vs:     !((r_vc >= 10'(VS_START)) && (r_vc <= 10'(VS_END)))
    };

    vga_sync_pipe #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_tick (w_tick),
        .i_sync (w_raw),
        .o_sync (w_dly)
    );

    // Colour arriving now belongs to the position carried by the delayed sync
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (w_tick) begin
            r_hsync <= w_dly.hs;
            r_vsync <= w_dly.vs;
            if (w_dly.active) begin
                {r_red, r_green, r_blue} <= expand_rgb332(rgb332_t'(color_in));
            end else begin
                {r_red, r_green, r_blue} <= 12'h000;
            end
        end
    end

    assign hc_out      = r_hc;
    assign vc_out      = r_vc;
    assign pix_tick    = w_tick;
    assign frame_start = w_tick && w_hWrap && w_vWrap;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench: full-geometry instances for line, colour and alignment;
// a shrunken 15x13 geometry instance keeps frame-level runs short.
module tb_vga_timing_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rstSmall;
    int   colorMode;
    int   checkCount;
    int   errorCount;

    logic [7:0] colorMain, colorPd0, colorPd3, colorSmall;
    logic [9:0] hcMain, vcMain, hc0, vc0, hc3, vc3, hcS, vcS;
    logic       tickMain, fsMain, hsMain, vsMain;
    logic       tick0, fs0, hs0, vs0;
    logic       tick3, fs3, hs3, vs3;
    logic       tickS, fsS, hsS, vsS;
    logic [3:0] redMain, greenMain, blueMain;
    logic [3:0] red0, green0, blue0;
    logic [3:0] red3, green3, blue3;
    logic [3:0] redS, greenS, blueS;

    always_comb begin
        case (colorMode)
            1:       colorMain = (hcMain >= 10'd641 || hcMain == 10'd0) ? 8'hFF : 8'hE0;
            2:       colorMain = 8'h03;
            default: colorMain = 8'hE0;
        endcase
    end

    assign colorPd0   = (hc0 == 10'd0) ? 8'hFF : 8'h00;
    assign colorPd3   = (hc3 == 10'd3) ? 8'hFF : 8'h00;
    assign colorSmall = 8'hFF;

    vga_timing_driver dutMain (
        .clk(clk), .rst(rst), .color_in(colorMain),
        .hc_out(hcMain), .vc_out(vcMain), .pix_tick(tickMain), .frame_start(fsMain),
        .hsync(hsMain), .vsync(vsMain), .red(redMain), .green(greenMain), .blue(blueMain)
    );

    vga_timing_driver #(.PIPE_DELAY(0)) dutPd0 (
        .clk(clk), .rst(rst), .color_in(colorPd0),
        .hc_out(hc0), .vc_out(vc0), .pix_tick(tick0), .frame_start(fs0),
        .hsync(hs0), .vsync(vs0), .red(red0), .green(green0), .blue(blue0)
    );

    vga_timing_driver #(.PIPE_DELAY(3)) dutPd3 (
        .clk(clk), .rst(rst), .color_in(colorPd3),
        .hc_out(hc3), .vc_out(vc3), .pix_tick(tick3), .frame_start(fs3),
        .hsync(hs3), .vsync(vs3), .red(red3), .green(green3), .blue(blue3)
    );

    vga_timing_driver #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(1)
    ) dutSmall (
        .clk(clk), .rst(rstSmall), .color_in(colorSmall),
        .hc_out(hcS), .vc_out(vcS), .pix_tick(tickS), .frame_start(fsS),
        .hsync(hsS), .vsync(vsS), .red(redS), .green(greenS), .blue(blueS)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstValue, input int mode);
        rst       = rstValue;
        colorMode = mode;
    endtask

    // Called at a negedge; returns at the negedge just after the main counters advance
    task automatic waitTick();
        int n;
        n = 0;
        while (tickMain !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (tickMain !== 1'b1) begin
            checkOutput("tickTimeout", 32'(tickMain), 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        int prevHc, prevVc, hsLow, hsFirst, lineErr, stepErr, wrapSeen;
        int white0, whiteHc0, white3, whiteHc3;
        int tickNum, fsCount, firstFs, secondFs, vsLow, vsFirstHc, vsFirstVc, fsPending;

        checkCount = 0;
        errorCount = 0;
        rstSmall   = 1'b1;
        applyStimulus(1'b1, 0);
        repeat (3) @(negedge clk);

        checkOutput("rstHc", 32'(hcMain), 32'd0);
        checkOutput("rstVc", 32'(vcMain), 32'd0);
        checkOutput("rstTick", 32'(tickMain), 32'd0);
        checkOutput("rstFrameStart", 32'(fsMain), 32'd0);
        checkOutput("rstHsync", 32'(hsMain), 32'd1);
        checkOutput("rstVsync", 32'(vsMain), 32'd1);
        checkOutput("rstRgb", 32'({redMain, greenMain, blueMain}), 32'h000);

        // Ticks every second clk; pixel 0 reaches the pins when hc_out reaches 2
        applyStimulus(1'b0, 0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("startTick%0d", k), 32'(tickMain), 32'(k % 2));
            checkOutput($sformatf("startHc%0d", k), 32'(hcMain), 32'(k / 2));
            checkOutput($sformatf("startHsync%0d", k), 32'(hsMain), 32'd1);
            if (k == 2) checkOutput("startRgbBlank", 32'({redMain, greenMain, blueMain}), 32'h000);
            if (k == 4) checkOutput("firstRedPixel", 32'({redMain, greenMain, blueMain}), 32'hF00);
        end

        // Line 0: hsync window, wrap, and blanking of 8'hFF outside the visible area
        applyStimulus(1'b0, 1);
        prevHc = int'(hcMain);
        prevVc = int'(vcMain);
        hsLow = 0; hsFirst = -1; lineErr = 0; stepErr = 0; wrapSeen = 0;
        for (int t = 0; t < 2000 && !(vcMain == 10'd1 && hcMain == 10'd0); t++) begin
            waitTick();
            if (prevHc == 799) begin
                checkOutput("wrapHc", 32'(hcMain), 32'd0);
                checkOutput("wrapVc", 32'(vcMain), 32'(prevVc + 1));
                wrapSeen = 1;
            end else if (int'(hcMain) != prevHc + 1 || int'(vcMain) != prevVc) begin
                stepErr++;
            end
            if (vcMain == 10'd0 && hsMain == 1'b0) begin
                if (hsFirst < 0) hsFirst = int'(hcMain);
                hsLow++;
            end
            if ({redMain, greenMain, blueMain} !==
                ((vcMain == 10'd0 && hcMain >= 10'd2 && hcMain <= 10'd641) ? 12'hF00 : 12'h000))
                lineErr++;
            if (vcMain == 10'd0 && hcMain == 10'd642)
                checkOutput("blankedWhite", 32'({redMain, greenMain, blueMain}), 32'h000);
            prevHc = int'(hcMain);
            prevVc = int'(vcMain);
        end
        checkOutput("wrapSeen", 32'(wrapSeen), 32'd1);
        checkOutput("hcStepErrors", 32'(stepErr), 32'd0);
        checkOutput("hsyncLowTicks", 32'(hsLow), 32'd96);
        checkOutput("hsyncFirstLowHc", 32'(hsFirst), 32'd658);
        checkOutput("lineColourErrors", 32'(lineErr), 32'd0);

        // Line 1: blue expansion and single-pixel alignment at PIPE_DELAY 0 and 3
        applyStimulus(1'b0, 2);
        white0 = 0; whiteHc0 = -1; white3 = 0; whiteHc3 = -1;
        for (int t = 0; t < 2000 && !(vcMain == 10'd2 && hcMain == 10'd0); t++) begin
            waitTick();
            if (vcMain == 10'd1 && hcMain == 10'd100)
                checkOutput("blueExpand", 32'({redMain, greenMain, blueMain}), 32'h00F);
            if (vc0 == 10'd1 && {red0, green0, blue0} == 12'hFFF) begin
                white0++;
                whiteHc0 = int'(hc0);
            end
            if (vc3 == 10'd1 && {red3, green3, blue3} == 12'hFFF) begin
                white3++;
                whiteHc3 = int'(hc3);
            end
        end
        checkOutput("pd0WhiteCount", 32'(white0), 32'd1);
        checkOutput("pd0WhiteHc", 32'(whiteHc0), 32'd1);
        checkOutput("pd3WhiteCount", 32'(white3), 32'd1);
        checkOutput("pd3WhiteHc", 32'(whiteHc3), 32'd4);

        // Small geometry, CLK_DIV=1: 15x13 = 195 ticks per frame, vsync lines 8..9
        @(negedge clk);
        rstSmall = 1'b0;
        #1;
        checkOutput("smallReleaseTick", 32'(tickS), 32'd1);
        tickNum = 1; fsCount = 0; firstFs = 0; secondFs = 0; fsPending = 0;
        vsLow = 0; vsFirstHc = -1; vsFirstVc = -1;
        for (int c = 0; c < 500 && fsCount < 2; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("smallFirstHc", 32'(hcS), 32'd1);
            if (fsPending == 1) begin
                checkOutput("frameStartWidth", 32'(fsS), 32'd0);
                checkOutput("frameOrigin", 32'({vcS, hcS}), 32'd0);
                fsPending = 0;
            end
            if (tickS == 1'b1) tickNum++;
            if (fsCount == 0 && vsS == 1'b0) begin
                if (vsFirstHc < 0) begin
                    vsFirstHc = int'(hcS);
                    vsFirstVc = int'(vcS);
                end
                vsLow++;
            end
            if (fsS == 1'b1) begin
                fsCount++;
                if (fsCount == 1) begin
                    firstFs   = tickNum;
                    fsPending = 1;
                end else begin
                    secondFs = tickNum;
                end
            end
        end
        checkOutput("frameStartCount", 32'(fsCount), 32'd2);
        checkOutput("firstFrameTicks", 32'(firstFs), 32'd195);
        checkOutput("framePeriod", 32'(secondFs - firstFs), 32'd195);
        checkOutput("vsyncLowTicks", 32'(vsLow), 32'd30);
        checkOutput("vsyncFirstHc", 32'(vsFirstHc), 32'd2);
        checkOutput("vsyncFirstVc", 32'(vsFirstVc), 32'd8);

        // Mid-frame reset while a visible pixel is on the pins
        for (int c = 0; c < 300 && !(hcS == 10'd5 && vcS == 10'd3); c++) @(negedge clk);
        checkOutput("preRstWhite", 32'({redS, greenS, blueS}), 32'hFFF);
        checkOutput("preRstVsync", 32'(vsS), 32'd1);
        rstSmall = 1'b1;
        @(negedge clk);
        checkOutput("midRstHc", 32'(hcS), 32'd0);
        checkOutput("midRstVc", 32'(vcS), 32'd0);
        checkOutput("midRstHsync", 32'(hsS), 32'd1);
        checkOutput("midRstVsync", 32'(vsS), 32'd1);
        checkOutput("midRstRgb", 32'({redS, greenS, blueS}), 32'h000);
        checkOutput("midRstTick", 32'(tickS), 32'd0);
        @(negedge clk);
        checkOutput("midRstTickHeld", 32'(tickS), 32'd0);
        rstSmall = 1'b0;
        #1;
        tickNum = (tickS == 1'b1) ? 1 : 0;
        firstFs = 0;
        for (int c = 0; c < 500 && firstFs == 0; c++) begin
            @(negedge clk);
            if (c == 0) checkOutput("resumeHc", 32'(hcS), 32'd1);
            if (tickS == 1'b1) tickNum++;
            if (fsS == 1'b1) firstFs = tickNum;
        end
        checkOutput("resumeFrameTicks", 32'(firstFs), 32'd195);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
